// File: rtl/aes_in_ctrl.sv
// Input-side controller of the AES-256 core: gathers host writes into a 128-bit
// block, offers it to the cipher with valid/ready and stalls the host until done.
module aes_in_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BLK_W  = 128,
  parameter int unsigned NFLAGS = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [NFLAGS-1:0] flags,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  input  logic              core_done,
  output logic [1:0]        word_cnt,
  output logic [7:0]        blk_count,
  output logic              err
);

  localparam int unsigned NWORDS = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned BCNT_W = 8;

  localparam logic [1:0] ADDR_FLAGS = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NFLAGS-1:0]   flags_q, flags_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                err_q, err_d;
  logic                data_wr_c;

  assign data_wr_c = wr_en && (state_q == IDLE) && (wr_addr == ADDR_DATA);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_wr_c && (cnt_q == CNT_W'(NWORDS - 1))) state_d = LOAD;
      LOAD:    if (blk_ready) state_d = BUSY;
      BUSY:    if (core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; blk_valid follows the async-reset state register
  always_comb begin
    wr_ready  = 1'b0;
    blk_valid = 1'b0;
    unique case (state_q)
      IDLE:    wr_ready  = 1'b1;
      LOAD:    blk_valid = 1'b1;
      default: ;
    endcase
  end

  // Host write decode; any write outside IDLE or to the reserved address is an error
  always_comb begin
    flags_d = flags_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;
    if (wr_en) begin
      if ((state_q != IDLE) || (wr_addr == ADDR_RSVD)) begin
        err_d = 1'b1;
      end else begin
        unique case (wr_addr)
          ADDR_FLAGS: flags_d = wr_data[NFLAGS-1:0];
          ADDR_DATA: begin
            for (int k = 0; k < NWORDS; k++) begin
              if (cnt_q == CNT_W'(k)) blk_d[k*DATA_W +: DATA_W] = wr_data;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
          ADDR_CLEAR: cnt_d = '0;
          default: ;
        endcase
      end
    end
    if ((state_q == BUSY) && core_done) bcnt_d = bcnt_q + BCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flags_q <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  assign flags     = flags_q;
  assign blk_data  = blk_q;
  assign word_cnt  = cnt_q;
  assign blk_count = bcnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_in_ctrl.sv
// Directed self-checking bench for aes_in_ctrl: load, handshake, errors, clear,
// blk_count wrap and asynchronous reset in LOAD and BUSY.
module tb_aes_in_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned NFLAGS = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [NFLAGS-1:0] flags;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_valid;
  logic              blk_ready;
  logic              core_done;
  logic [1:0]        word_cnt;
  logic [7:0]        blk_count;
  logic              err;

  int checks   = 0;
  int failures = 0;

  aes_in_ctrl #(.DATA_W(DATA_W), .BLK_W(BLK_W), .NFLAGS(NFLAGS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .flags     (flags),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .core_done (core_done),
    .word_cnt  (word_cnt),
    .blk_count (blk_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BLK_W-1:0] got,
                       input logic [BLK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"},  BLK_W'(wr_ready),  BLK_W'(1));
    check({tag, "_flags"},     BLK_W'(flags),     BLK_W'(0));
    check({tag, "_blk_data"},  blk_data,          BLK_W'(0));
    check({tag, "_blk_valid"}, BLK_W'(blk_valid), BLK_W'(0));
    check({tag, "_word_cnt"},  BLK_W'(word_cnt),  BLK_W'(0));
    check({tag, "_blk_count"}, BLK_W'(blk_count), BLK_W'(0));
    check({tag, "_err"},       BLK_W'(err),       BLK_W'(0));
  endtask

  // Complete block with blk_ready already high: one LOAD cycle, then core_done
  task automatic run_block();
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(2'd1, DATA_W'(i));
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    blk_ready = 1'b0;
  endtask

  initial begin
    logic [BLK_W-1:0] blk_a;
    logic [BLK_W-1:0] blk_b;
    logic [BLK_W-1:0] blk_c;
    blk_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    blk_b = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    blk_c = 128'h44444444_33333333_22222222_11111111;

    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    blk_ready = 1'b0; core_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rstn = 1'b1;
    tick();

    // Flags and four data words
    wr(2'd0, 32'h0000_00A5);
    check("flags_a5", BLK_W'(flags), BLK_W'(8'hA5));
    check("cnt_after_flags", BLK_W'(word_cnt), BLK_W'(0));
    wr(2'd1, 32'h0302_0100);
    check("cnt1", BLK_W'(word_cnt), BLK_W'(1));
    wr(2'd1, 32'h0706_0504);
    wr(2'd1, 32'h0B0A_0908);
    check("cnt3", BLK_W'(word_cnt), BLK_W'(3));
    check("valid_before_last", BLK_W'(blk_valid), BLK_W'(0));
    wr(2'd1, 32'h0F0E_0D0C);
    check("valid_after_last", BLK_W'(blk_valid), BLK_W'(1));
    check("blk_a", blk_data, blk_a);
    check("cnt_wrap", BLK_W'(word_cnt), BLK_W'(0));
    check("wr_ready_load", BLK_W'(wr_ready), BLK_W'(0));

    // Backpressure: hold blk_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("valid_hold", BLK_W'(blk_valid), BLK_W'(1));
      check("data_hold", blk_data, blk_a);
    end
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    check("busy_valid", BLK_W'(blk_valid), BLK_W'(0));
    check("busy_wr_ready", BLK_W'(wr_ready), BLK_W'(0));
    tick();
    check("busy_wr_ready2", BLK_W'(wr_ready), BLK_W'(0));

    // Write while BUSY is dropped with an error pulse
    wr(2'd1, 32'hDEAD_BEEF);
    check("err_busy", BLK_W'(err), BLK_W'(1));
    check("busy_wr_data", blk_data, blk_a);
    check("busy_wr_cnt", BLK_W'(word_cnt), BLK_W'(0));
    wr(2'd0, 32'h0000_0033);
    check("busy_wr_flags", BLK_W'(flags), BLK_W'(8'hA5));
    tick();
    check("err_clear", BLK_W'(err), BLK_W'(0));
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("done_wr_ready", BLK_W'(wr_ready), BLK_W'(1));
    check("done_count1", BLK_W'(blk_count), BLK_W'(1));

    // Reserved address in IDLE
    wr(2'd3, 32'h1234_5678);
    check("err_rsvd", BLK_W'(err), BLK_W'(1));
    check("rsvd_flags", BLK_W'(flags), BLK_W'(8'hA5));
    check("rsvd_data", blk_data, blk_a);
    check("rsvd_cnt", BLK_W'(word_cnt), BLK_W'(0));
    check("rsvd_wr_ready", BLK_W'(wr_ready), BLK_W'(1));
    tick();
    check("err_rsvd_clear", BLK_W'(err), BLK_W'(0));

    // Two words, clear, then four words with blk_ready already high
    wr(2'd1, 32'h1111_1111);
    check("clr_cnt1", BLK_W'(word_cnt), BLK_W'(1));
    wr(2'd1, 32'h2222_2222);
    check("clr_cnt2", BLK_W'(word_cnt), BLK_W'(2));
    wr(2'd2, 32'h0);
    check("clr_cnt0", BLK_W'(word_cnt), BLK_W'(0));
    check("clr_keeps_flags", BLK_W'(flags), BLK_W'(8'hA5));
    check("clr_keeps_data", blk_data,
          128'h0F0E0D0C_0B0A0908_22222222_11111111);
    wr(2'd1, 32'hAAAA_0000);
    wr(2'd1, 32'hAAAA_0001);
    wr(2'd1, 32'hAAAA_0002);
    blk_ready = 1'b1;
    wr(2'd1, 32'hAAAA_0003);
    check("blk_b", blk_data, blk_b);
    check("single_load_valid", BLK_W'(blk_valid), BLK_W'(1));
    tick();
    blk_ready = 1'b0;
    check("single_load_busy", BLK_W'(blk_valid), BLK_W'(0));
    check("single_load_wr_ready", BLK_W'(wr_ready), BLK_W'(0));
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("done_count2", BLK_W'(blk_count), BLK_W'(2));

    // Spurious core_done in IDLE
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("spur_count", BLK_W'(blk_count), BLK_W'(2));
    check("spur_wr_ready", BLK_W'(wr_ready), BLK_W'(1));
    check("spur_err", BLK_W'(err), BLK_W'(0));

    // Wrap blk_count through 255 to 0
    for (int b = 0; b < 253; b++) run_block();
    check("count255", BLK_W'(blk_count), BLK_W'(255));
    run_block();
    check("count_wrap", BLK_W'(blk_count), BLK_W'(0));
    check("wrap_data", blk_data, 128'h00000003_00000002_00000001_00000000);

    // Asynchronous reset mid-LOAD drops blk_valid without a clock edge
    for (int i = 0; i < 4; i++) wr(2'd1, 32'h5555_0000 + DATA_W'(i));
    check("preload_valid", BLK_W'(blk_valid), BLK_W'(1));
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    tick();
    rstn = 1'b1;
    tick();

    // Asynchronous reset mid-BUSY
    wr(2'd0, 32'h0000_005A);
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(2'd1, 32'h6666_0000 + DATA_W'(i));
    tick();
    blk_ready = 1'b0;
    check("pre_rst_busy", BLK_W'(wr_ready), BLK_W'(0));
    wr(2'd3, 32'h0);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_busy");
    tick();
    rstn = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    // Fresh block after reset
    wr(2'd1, 32'h1111_1111);
    wr(2'd1, 32'h2222_2222);
    wr(2'd1, 32'h3333_3333);
    wr(2'd1, 32'h4444_4444);
    check("fresh_valid", BLK_W'(blk_valid), BLK_W'(1));
    check("fresh_blk", blk_data, blk_c);
    check("fresh_flags", BLK_W'(flags), BLK_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_in_ctrl.md
# aes_in_ctrl

Input-side controller of the AES-256 core. It accepts 32-bit host writes on a small address map and captures the 8-bit flag register. It assembles four data writes into one 128-bit block, presents the block to the cipher datapath with a valid/ready handshake, and holds off the host until the core reports completion. It sits between the host bus and the core's input demultiplexing, sequencing what was previously a purely combinational routing step.

## Interface
Parameters:
- DATA_W, 32, host write word width
- BLK_W, 128, block width; must equal 4*DATA_W
- NFLAGS, 8, flag register width

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- wr_en  in  1  host write strobe, one write per cycle
- wr_addr  in  2  0 = flags, 1 = data word, 2 = clear, 3 = reserved
- wr_data  in  DATA_W  host write data
- wr_ready  out  1  host may write this cycle
- flags  out  NFLAGS  captured flag register
- blk_data  out  BLK_W  assembled block; word k at bits [32k +: 32]
- blk_valid  out  1  block offered to core
- blk_ready  in  1  core accepts block
- core_done  in  1  one-cycle pulse, core finished the block
- word_cnt  out  2  data words collected for the current block
- blk_count  out  8  completed blocks, wraps
- err  out  1  one-cycle pulse on illegal access

## Operation
- FSM states: IDLE, LOAD, BUSY.
- In IDLE, wr_ready=1. In LOAD and BUSY, wr_ready=0.
- IDLE, wr_en with addr 0: flags <= wr_data[NFLAGS-1:0]. word_cnt is unchanged.
- IDLE, wr_en with addr 1: blk_data[32*word_cnt +: 32] <= wr_data and word_cnt increments.
  - If word_cnt was 3, word_cnt returns to 0 and the state goes to LOAD.
- IDLE, wr_en with addr 2: word_cnt <= 0. blk_data and flags are unchanged.
- wr_en with addr 3 in any state: err pulses and nothing else changes.
- wr_en in LOAD or BUSY with any address: the write is dropped and err pulses.
- LOAD: blk_valid=1, with blk_data and flags held stable.
  - When blk_valid and blk_ready are both high, the state goes to BUSY.
- BUSY: blk_valid=0. A core_done pulse moves the state to IDLE and increments blk_count (255 wraps to 0).
- core_done in IDLE or LOAD is ignored: no state change, no counter change, no err.
- flags and blk_data persist across blocks. Only a data or flags write changes them.

## Timing
- Reset values: state IDLE, wr_ready=1, flags=0, blk_data=0, blk_valid=0, word_cnt=0, blk_count=0, err=0.
- Reset takes effect immediately when rstn falls, including mid-LOAD and mid-BUSY. blk_valid drops asynchronously.
- All other outputs are registered or decoded from the registered state only. There are no combinational paths from inputs to outputs.
- Fourth data write at edge N gives blk_valid=1 in cycle N+1.
- Handshake at edge M gives blk_valid=0 and the BUSY state from cycle M+1.
  - blk_ready already high when blk_valid rises means a single LOAD cycle.
- core_done sampled at edge D gives wr_ready=1 and an updated blk_count in cycle D+1. The next block's first write can land at edge D+1.
- err is registered: high for exactly one cycle after the offending edge.
- Minimum block period is 4 write cycles + 1 LOAD cycle + core latency + 1.

## Test plan
- Reset, then flags write 0x000000A5 and data writes 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> flags=0xA5, blk_data=0x0F0E0D0C_0B0A0908_07060504_03020100, and blk_valid rises one cycle after the last write.
- Hold blk_ready=0 for 5 cycles, then 1 -> blk_valid stays high with data stable for the whole wait, the state goes to BUSY one cycle after the handshake, and wr_ready stays 0 until core_done.
- A write while BUSY, plus a write to addr 3 in IDLE -> err pulses one cycle for each, and flags, blk_data and word_cnt are unchanged.
- Two data writes, then a clear, then four data writes -> word_cnt goes 1, 2, 0, and the block contains only the last four words.
- Run 256 blocks -> blk_count wraps to 0. A spurious core_done in IDLE causes no change.
- Assert rstn low mid-BUSY, then release -> all outputs return to their reset values, and a fresh 4-word block loads correctly.
